// File: rtl/mult_pkg.sv
// Shared encodings for the 8x8 sequential multiplier: controller state codes,
// shifter selects and nibble-pair selects used by controller, datapath and display.
package mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LSB       = 3'd1,
        ST_MID       = 3'd2,
        ST_MSB       = 3'd3,
        ST_CALC_DONE = 3'd4,
        ST_ERR       = 3'd5
    } state_e;

    localparam logic [1:0] SHIFT_0 = 2'b00;
    localparam logic [1:0] SHIFT_4 = 2'b01;
    localparam logic [1:0] SHIFT_8 = 2'b10;

    // {a_sel, b_sel}: 0 picks the low nibble, 1 the high nibble
    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LSB) || (s == ST_MID) || (s == ST_MSB);
    endfunction

endpackage

// File: rtl/mult_slice_cnt.sv
// Slice counter for the multiplier controller: counts partial products,
// synchronous clear has priority over enable.
module mult_slice_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ena,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (ena) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the 8x8 sequential multiplier: clears the accumulator on start,
// then steps four nibble partial products through the shifter into it.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int NSLICE = 4,
    parameter int CNT_W  = 2
) (
    input  logic       clk,
    input  logic       sclr,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       acc_clk_ena,
    output logic       acc_sclr_n,
    output logic       done,
    output logic       err,
    output logic [2:0] state_out
);

    state_e           state_d;
    state_e           state_q;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             cnt_clr;
    logic             cnt_ena;

    assign busy    = is_busy(state_q);
    assign cnt_ena = busy;
    // A start while busy aborts into ERR, so the counter must restart from zero.
    assign cnt_clr = sclr || start || !busy;

    mult_slice_cnt #(
        .CNT_W(CNT_W)
    ) u_slice_cnt (
        .clk  (clk),
        .clr  (cnt_clr),
        .ena  (cnt_ena),
        .count(count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = start ? ST_LSB : ST_IDLE;
            ST_LSB:       state_d = start ? ST_ERR : ST_MID;
            ST_MID: begin
                if (start) begin
                    state_d = ST_ERR;
                end else if (count == CNT_W'(NSLICE - 2)) begin
                    state_d = ST_MSB;
                end
            end
            ST_MSB:       state_d = start ? ST_ERR : ST_CALC_DONE;
            ST_CALC_DONE: state_d = start ? ST_LSB : ST_CALC_DONE;
            ST_ERR:       state_d = start ? ST_ERR : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE and CALC_DONE clear the accumulator in the same cycle start is seen,
    // so the first partial product lands on a zeroed register.
    always_comb begin
        input_sel   = SEL_LL;
        shift_sel   = SHIFT_0;
        acc_clk_ena = 1'b0;
        acc_sclr_n  = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        if (sclr) begin
            acc_clk_ena = 1'b1;
            acc_sclr_n  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_clk_ena = start;
                    acc_sclr_n  = !start;
                end
                ST_LSB: begin
                    acc_clk_ena = 1'b1;
                end
                ST_MID: begin
                    input_sel   = (count == CNT_W'(1)) ? SEL_LH : SEL_HL;
                    shift_sel   = SHIFT_4;
                    acc_clk_ena = 1'b1;
                end
                ST_MSB: begin
                    input_sel   = SEL_HH;
                    shift_sel   = SHIFT_8;
                    acc_clk_ena = 1'b1;
                end
                ST_CALC_DONE: begin
                    done        = 1'b1;
                    acc_clk_ena = start;
                    acc_sclr_n  = !start;
                end
                ST_ERR: begin
                    err = 1'b1;
                end
                default: begin
                    input_sel = SEL_LL;
                end
            endcase
        end
    end

    assign state_out = 3'(state_q);

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer wrapped in a behavioural 8x8 datapath with a 16-bit
// accumulator; a mode/step model is compared against the DUT every cycle.
module tb_mult_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic       clk;
    logic       sclr;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       acc_clk_ena;
    logic       acc_sclr_n;
    logic       done;
    logic       err;
    logic [2:0] state_out;

    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;
    logic [15:0] acc;

    int checks;
    int failures;

    int          m_mode;
    int          m_step;
    logic        m_valid;
    logic        m_acc_known;
    logic [15:0] m_acc;

    mult_sequencer #(
        .NSLICE(4),
        .CNT_W (2)
    ) dut (
        .clk        (clk),
        .sclr       (sclr),
        .start      (start),
        .input_sel  (input_sel),
        .shift_sel  (shift_sel),
        .acc_clk_ena(acc_clk_ena),
        .acc_sclr_n (acc_sclr_n),
        .done       (done),
        .err        (err),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Datapath: nibble muxes, 4x4 multiplier, shifter, adder and reg16 accumulator.
    always_comb begin
        a_nib = input_sel[1] ? a[7:4] : a[3:0];
        b_nib = input_sel[0] ? b[7:4] : b[3:0];
        pp    = a_nib * b_nib;
        case (shift_sel)
            2'b01:   pp_shifted = {4'h0, pp, 4'h0};
            2'b10:   pp_shifted = {pp, 8'h00};
            default: pp_shifted = {8'h00, pp};
        endcase
    end

    always @(posedge clk) begin
        if (acc_clk_ena) begin
            acc <= acc_sclr_n ? (acc + pp_shifted) : 16'h0000;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_sclr, input int cycles);
        start = s_start;
        sclr  = s_sclr;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: a multiply is four steps after an accepted start, then the product a*b is held.
    always @(posedge clk) begin
        if (sclr) begin
            m_mode      <= M_IDLE;
            m_step      <= 0;
            m_acc_known <= 1'b1;
            m_acc       <= 16'h0000;
            m_valid     <= 1'b1;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_mode      <= M_BUSY;
                        m_step      <= 0;
                        m_acc_known <= 1'b0;
                        m_acc       <= 16'(a) * 16'(b);
                    end
                end
                M_BUSY: begin
                    if (start) begin
                        m_mode <= M_ERR;
                    end else if (m_step == 3) begin
                        m_mode      <= M_DONE;
                        m_acc_known <= 1'b1;
                    end else begin
                        m_step <= m_step + 1;
                    end
                end
                default: begin
                    if (!start) m_mode <= M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [1:0] e_sel;
        logic [1:0] e_shift;
        logic       e_ena;
        logic       e_sclr_n;
        logic       e_done;
        logic       e_err;
        logic [2:0] e_state;
        logic [1:0] sel_tab [4];
        logic [1:0] shift_tab [4];
        sel_tab   = '{2'd0, 2'd1, 2'd2, 2'd3};
        shift_tab = '{2'd0, 2'd1, 2'd1, 2'd2};
        if (m_valid) begin
            e_sel    = 2'd0;
            e_shift  = 2'd0;
            e_ena    = 1'b0;
            e_sclr_n = 1'b1;
            e_done   = 1'b0;
            e_err    = 1'b0;
            case (m_mode)
                M_IDLE:  e_state = 3'd0;
                M_BUSY:  e_state = (m_step == 0) ? 3'd1 : ((m_step == 3) ? 3'd3 : 3'd2);
                M_DONE:  e_state = 3'd4;
                default: e_state = 3'd5;
            endcase
            if (sclr) begin
                e_ena    = 1'b1;
                e_sclr_n = 1'b0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        e_ena    = start;
                        e_sclr_n = !start;
                    end
                    M_BUSY: begin
                        e_sel   = sel_tab[m_step];
                        e_shift = shift_tab[m_step];
                        e_ena   = 1'b1;
                    end
                    M_DONE: begin
                        e_done   = 1'b1;
                        e_ena    = start;
                        e_sclr_n = !start;
                    end
                    default: e_err = 1'b1;
                endcase
            end
            checkOutput("cyc_input_sel", 16'(input_sel), 16'(e_sel));
            checkOutput("cyc_shift_sel", 16'(shift_sel), 16'(e_shift));
            checkOutput("cyc_acc_clk_ena", 16'(acc_clk_ena), 16'(e_ena));
            checkOutput("cyc_acc_sclr_n", 16'(acc_sclr_n), 16'(e_sclr_n));
            checkOutput("cyc_done", 16'(done), 16'(e_done));
            checkOutput("cyc_err", 16'(err), 16'(e_err));
            checkOutput("cyc_state_out", 16'(state_out), 16'(e_state));
            if (m_acc_known) begin
                checkOutput("cyc_acc", acc, m_acc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_valid  = 1'b0;
        m_mode   = M_IDLE;
        m_step   = 0;
        m_acc_known = 1'b0;
        m_acc    = 16'h0000;
        a        = 8'hFF;
        b        = 8'hFF;
        start    = 1'b0;
        sclr     = 1'b1;

        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("rst_state", 16'(state_out), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_err", 16'(err), 16'd0);
        checkOutput("rst_acc_sclr_n", 16'(acc_sclr_n), 16'd0);
        checkOutput("rst_acc", acc, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("ff_lsb_state", 16'(state_out), 16'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("ff_mid1_sel", 16'(input_sel), 16'd1);
        checkOutput("ff_mid1_shift", 16'(shift_sel), 16'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("ff_mid2_sel", 16'(input_sel), 16'd2);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("ff_msb_sel", 16'(input_sel), 16'd3);
        checkOutput("ff_msb_shift", 16'(shift_sel), 16'd2);
        checkOutput("ff_msb_done", 16'(done), 16'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("ff_done", 16'(done), 16'd1);
        checkOutput("ff_product", acc, 16'hFE01);

        a = 8'h0C;
        b = 8'h0A;
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 7);
        checkOutput("c_a_done_held", 16'(done), 16'd1);
        checkOutput("c_a_product", acc, 16'h0078);

        a = 8'h12;
        b = 8'h34;
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("second_lsb_state", 16'(state_out), 16'd1);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("second_done", 16'(done), 16'd1);
        checkOutput("second_product", acc, 16'h03A8);

        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("err_state", 16'(state_out), 16'd5);
        checkOutput("err_flag", 16'(err), 16'd1);
        checkOutput("err_ena", 16'(acc_clk_ena), 16'd0);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("err_hold_state", 16'(state_out), 16'd5);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("err_exit_state", 16'(state_out), 16'd0);
        checkOutput("err_exit_flag", 16'(err), 16'd0);

        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("sclr_mid_state", 16'(state_out), 16'd0);
        checkOutput("sclr_mid_acc", acc, 16'h0000);
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("sclr_mid_no_done", 16'(done), 16'd0);

        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("both_state", 16'(state_out), 16'd0);
        checkOutput("both_acc", acc, 16'h0000);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("both_no_lsb", 16'(state_out), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
